// File: rtl/cam_controller_if.sv
// ---------------------------------------------------------------------------
// cam_controller_if
//  Request/response handshake bundle between a client and cam_controller.
//  Signal names keep the controller-side _i/_o suffixes so they trace
//  directly to the original port list.
//
//  Request  : req_valid_i, req_ready_o, req_op_i, req_index_i, req_data_i
//  Response : resp_valid_o, resp_ready_i, resp_hit_o, resp_index_o, resp_data_o
//
//  Modports:
//    master - the client issuing requests and consuming responses
//    slave  - the controller
// ---------------------------------------------------------------------------
interface cam_controller_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic [ADDR_WIDTH-1:0] req_index_i;
  logic [DATA_WIDTH-1:0] req_data_i;

  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic                  resp_hit_o;
  logic [ADDR_WIDTH-1:0] resp_index_o;
  logic [DATA_WIDTH-1:0] resp_data_o;

  modport master (
    output req_valid_i, req_op_i, req_index_i, req_data_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_hit_o, resp_index_o, resp_data_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_index_i, req_data_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_hit_o, resp_index_o, resp_data_o
  );
endinterface

// File: rtl/cam_controller.sv
// ---------------------------------------------------------------------------
// cam_controller
//  Sequences a DEPTH x DATA_WIDTH CAM array. One operation (read, write,
//  search, invalidate) is accepted per request handshake, the matching CAM
//  strobe is driven for exactly one cycle, the result is captured after
//  CAM_LATENCY cycles and returned as a held response. The controller owns
//  the per-entry valid bits and priority-encodes qualified search matches.
//
//  Ports:
//    clk_i, reset_i      clock, synchronous active-high reset
//    bus (slave)         request/response handshake (cam_controller_if)
//    cam_read_o/_write_o/_search_o   one-cycle CAM strobes
//    cam_read_index_o, cam_write_index_o, cam_write_data_o, cam_search_data_o
//                        strobe qualifiers, forced to 0 while the strobe is low
//    cam_data_i          CAM read data, valid CAM_LATENCY cycles after strobe
//    cam_match_i         raw CAM match vector, bit n = entry n
//
//  Optional feature macro: CAM_CTRL_STATS_EN
//    Adds stat_hits_o / stat_misses_o, saturating 16-bit counts of search
//    responses (counted at the response handshake).
// ---------------------------------------------------------------------------
module cam_controller #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DEPTH       = 1 << ADDR_WIDTH,
  parameter int unsigned CAM_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  cam_controller_if.slave       bus,
  output logic                  cam_read_o,
  output logic                  cam_write_o,
  output logic                  cam_search_o,
  output logic [ADDR_WIDTH-1:0] cam_read_index_o,
  output logic [ADDR_WIDTH-1:0] cam_write_index_o,
  output logic [DATA_WIDTH-1:0] cam_write_data_o,
  output logic [DATA_WIDTH-1:0] cam_search_data_o,
  input  logic [DATA_WIDTH-1:0] cam_data_i,
  input  logic [DEPTH-1:0]      cam_match_i
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [15:0]           stat_hits_o,
  output logic [15:0]           stat_misses_o
`endif
);

  localparam int unsigned CNT_W = $clog2(CAM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SEARCH = 2'b10,
    OP_INVAL  = 2'b11
  } op_e;

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  resp_hit_q, resp_hit_d;
  logic [ADDR_WIDTH-1:0] resp_index_q, resp_index_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  // Search qualification and lowest-index priority encoder
  logic [DEPTH-1:0]      qualified;
  logic                  match_any;
  logic [ADDR_WIDTH-1:0] match_idx;

  always_comb begin
    qualified = cam_match_i & valid_q;
    match_any = |qualified;
    match_idx = '0;
    // Scan downward so the lowest set bit is the last one written
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (qualified[i-1]) match_idx = ADDR_WIDTH'(i - 1);
    end
  end

  // Next-state, datapath and CAM strobe decode
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    index_d      = index_q;
    data_d       = data_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    resp_hit_d   = resp_hit_q;
    resp_index_d = resp_index_q;
    resp_data_d  = resp_data_q;
    cam_read_o   = 1'b0;
    cam_write_o  = 1'b0;
    cam_search_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          op_d    = op_e'(bus.req_op_i);
          index_d = bus.req_index_i;
          data_d  = bus.req_data_i;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        unique case (op_q)
          OP_WRITE: begin
            cam_write_o      = 1'b1;
            valid_d[index_q] = 1'b1;
            resp_hit_d       = 1'b1;
            resp_index_d     = index_q;
            resp_data_d      = '0;
            state_d          = S_RESP;
          end
          OP_INVAL: begin
            valid_d[index_q] = 1'b0;
            resp_hit_d       = 1'b1;
            resp_index_d     = index_q;
            resp_data_d      = '0;
            state_d          = S_RESP;
          end
          OP_READ: begin
            cam_read_o = 1'b1;
            cnt_d      = CNT_W'(CAM_LATENCY);
            state_d    = S_WAIT;
          end
          OP_SEARCH: begin
            cam_search_o = 1'b1;
            cnt_d        = CNT_W'(CAM_LATENCY);
            state_d      = S_WAIT;
          end
        endcase
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Counter leaves WAIT on its final count so the sample lands exactly
        // CAM_LATENCY cycles after the strobe cycle.
        if (cnt_q == CNT_W'(1)) begin
          if (op_q == OP_SEARCH) begin
            resp_hit_d   = match_any;
            resp_index_d = match_idx;
            resp_data_d  = '0;
          end else begin
            resp_hit_d   = valid_q[index_q];
            resp_index_d = index_q;
            resp_data_d  = cam_data_i;
          end
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.resp_ready_i) state_d = S_IDLE;
      end
    endcase

    cam_read_index_o  = cam_read_o   ? index_q : '0;
    cam_write_index_o = cam_write_o  ? index_q : '0;
    cam_write_data_o  = cam_write_o  ? data_q  : '0;
    cam_search_data_o = cam_search_o ? data_q  : '0;
  end

  assign bus.req_ready_o  = (state_q == S_IDLE);
  assign bus.resp_valid_o = (state_q == S_RESP);
  assign bus.resp_hit_o   = resp_hit_q;
  assign bus.resp_index_o = resp_index_q;
  assign bus.resp_data_o  = resp_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      op_q         <= OP_READ;
      index_q      <= '0;
      data_q       <= '0;
      valid_q      <= '0;
      cnt_q        <= '0;
      resp_hit_q   <= 1'b0;
      resp_index_q <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      index_q      <= index_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      resp_hit_q   <= resp_hit_d;
      resp_index_q <= resp_index_d;
      resp_data_q  <= resp_data_d;
    end
  end

`ifdef CAM_CTRL_STATS_EN
  logic [15:0] hits_q, hits_d;
  logic [15:0] misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == S_RESP && bus.resp_ready_i && op_q == OP_SEARCH) begin
      if (resp_hit_q) begin
        if (hits_q != '1) hits_d = hits_q + 16'd1;
      end else begin
        if (misses_q != '1) misses_d = misses_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits_o   = hits_q;
  assign stat_misses_o = misses_q;
`endif

endmodule
